// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-stage controller doing 32-bit loads/stores as two half-word phases on a 16-bit async SRAM
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   rd_en, wr_en           load/store request from the EXE stage register (write wins if both)
//   address, write_data    byte address and store value, held by the frozen pipeline during an access
//   read_data              loaded word, registered, holds between accesses
//   ready                  0 freezes the pipeline while an access is in flight
//   SRAM_ADDR, SRAM_DQ     half-word address and bidirectional data bus
//   SRAM_WE_N, SRAM_OE_N   active-low write strobe and output enable
// Optional: define SRAM_LAST_READ_BYPASS_EN for a one-entry last-read buffer that serves repeat loads with no stall.
module mem_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  logic [1:0]         r_state, w_st, w_nstate;
  logic [CW-1:0]      r_cnt, w_cnt, w_ncnt;
  logic               r_op, w_wr, w_req, w_hit, w_last, w_act;
  logic [SRAM_AW-2:0] w_word;
  logic [15:0]        r_lo;
  logic [31:0]        r_rd, w_bp_data;
  assign w_word = (SRAM_AW-1)'((address - ADDR_BASE) >> 2);
  // The request cycle in IDLE already acts as the first LO cycle, so an
  // access takes 2*WAIT_CYCLES stalled cycles followed by one DONE cycle.
  always_comb begin
    w_req    = rd_en | wr_en;
    w_st     = (r_state == S_IDLE && w_req && !w_hit) ? S_LO : r_state;
    w_cnt    = (r_state == S_IDLE) ? '0 : r_cnt;
    w_wr     = (r_state == S_IDLE) ? wr_en : r_op;
    w_last   = w_cnt == CW'(WAIT_CYCLES - 1);
    w_act    = w_st == S_LO || w_st == S_HI;
    w_nstate = w_st == S_LO ? (w_last ? S_HI : S_LO) :
               w_st == S_HI ? (w_last ? S_DONE : S_HI) : S_IDLE;
    w_ncnt   = (w_act && !w_last) ? w_cnt + 1'b1 : '0;
  end
  assign ready     = (r_state == S_IDLE && (!w_req || w_hit)) || r_state == S_DONE;
  assign SRAM_WE_N = !(w_act && w_wr);
  assign SRAM_OE_N = !(w_act && !w_wr);
  assign SRAM_ADDR = w_act ? {w_word, w_st == S_HI} : '0;
  assign SRAM_DQ   = SRAM_WE_N ? 16'bz : (w_st == S_HI ? write_data[31:16] : write_data[15:0]);
  assign read_data = w_hit ? w_bp_data : r_rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_lo    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (r_state == S_IDLE) r_op <= wr_en;
      if (w_act && !w_wr && w_last && w_st == S_LO) r_lo <= SRAM_DQ;
      if (w_act && !w_wr && w_last && w_st == S_HI) r_rd <= {SRAM_DQ, r_lo};
      if (w_hit) r_rd <= w_bp_data;
    end
  end
`ifdef SRAM_LAST_READ_BYPASS_EN
  logic               r_bp_v;
  logic [SRAM_AW-2:0] r_bp_word;
  logic [31:0]        r_bp_data;
  // Tag compares the truncated SRAM word so aliased addresses share the entry.
  assign w_hit     = r_state == S_IDLE && rd_en && !wr_en && r_bp_v && r_bp_word == w_word;
  assign w_bp_data = r_bp_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp_v    <= 1'b0;
      r_bp_word <= '0;
      r_bp_data <= '0;
    end else if (r_state == S_DONE) begin
      if (!r_op) begin
        r_bp_v    <= 1'b1;
        r_bp_word <= w_word;
        r_bp_data <= r_rd;
      end else if (r_bp_v && r_bp_word == w_word) begin
        r_bp_data <= write_data;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_bp_data = '0;
`endif
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: randomized self-checking bench for mem_sram_ctrl with a behavioural SRAM and word-level reference memory
module tb_mem_sram_ctrl;
  localparam int          W    = 2;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;
  logic          clk = 1'b0, rst = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   address = '0, write_data = '0;
  wire  [31:0]   read_data;
  wire           ready, SRAM_WE_N, SRAM_OE_N;
  wire  [AW-1:0] SRAM_ADDR;
  wire  [15:0]   SRAM_DQ;
  logic [15:0]   sram [0:(1<<AW)-1];
  logic [31:0]   ref_mem [int unsigned];
  bit            bp_v = 1'b0;
  int unsigned   bp_word = 0;
  int            nvec = 0, nerr = 0;
  int            stall, we_lo, oe_lo, addr_bad, dq_bad;
  bit            act_bad;
  logic [31:0]   rdat;
  always #5 clk = ~clk;
  mem_sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;
  function automatic int unsigned word_of(input logic [31:0] a);
    return ((a - BASE) >> 2) & ((1 << (AW - 1)) - 1);
  endfunction
  // Reference: word memory plus last-read tag; returns expected stall cycles.
  function automatic int model(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int unsigned k = word_of(a);
    if (w) begin
      ref_mem[k] = d;
      return 2 * W;
    end
    if (!r) return 0;
`ifdef SRAM_LAST_READ_BYPASS_EN
    if (bp_v && bp_word == k) return 0;
    bp_v = 1'b1;
    bp_word = k;
`endif
    return 2 * W;
  endfunction
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    int unsigned k = word_of(a);
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    stall = 0; we_lo = 0; oe_lo = 0; addr_bad = 0; dq_bad = 0;
    while (!ready && stall < 50) begin
      if (!SRAM_WE_N) we_lo++;
      if (!SRAM_OE_N) oe_lo++;
      if (SRAM_ADDR !== AW'(2 * k + (stall >= W ? 1 : 0))) addr_bad++;
      if (!SRAM_OE_N && SRAM_DQ !== sram[SRAM_ADDR]) dq_bad++;
      stall++;
      @(negedge clk);
      #1;
    end
    act_bad = !SRAM_WE_N || !SRAM_OE_N;
    rdat = read_data;
  endtask
  task automatic drop();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b exp=1", ready); end
    nvec++; if (read_data !== 32'h0) begin nerr++; $display("FAIL reset_rdata got=%h exp=00000000", read_data); end
    nvec++; if ({SRAM_WE_N, SRAM_OE_N, SRAM_ADDR} !== {2'b11, AW'(0)}) begin nerr++; $display("FAIL reset_sram got we=%b oe=%b addr=%h exp we=1 oe=1 addr=0", SRAM_WE_N, SRAM_OE_N, SRAM_ADDR); end
  endtask
  task automatic test_idle();
    int bad = 0;
    drop();
    repeat (4) begin
      #1;
      if (!ready || !SRAM_WE_N || !SRAM_OE_N) bad++;
      @(negedge clk);
    end
    nvec++; if (bad != 0) begin nerr++; $display("FAIL idle_quiet got=%0d active cycles exp=0", bad); end
  endtask
  task automatic test_store_load();
    int e = model(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    nvec++; if (stall != 2 * W || e != 2 * W) begin nerr++; $display("FAIL store_stall got=%0d exp=%0d", stall, 2 * W); end
    nvec++; if (we_lo != 2 * W || oe_lo != 0) begin nerr++; $display("FAIL store_strobe got we=%0d oe=%0d exp we=%0d oe=0", we_lo, oe_lo, 2 * W); end
    nvec++; if ({sram[1], sram[0]} !== 32'hDEADBEEF) begin nerr++; $display("FAIL store_sram got=%h exp=deadbeef", {sram[1], sram[0]}); end
    nvec++; if (addr_bad != 0 || act_bad) begin nerr++; $display("FAIL store_addr got=%0d bad addr, done_active=%b exp=0,0", addr_bad, act_bad); end
    e = model(1'b0, 1'b1, 32'd1024, 32'h0);
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    nvec++; if (stall != e || oe_lo != e || we_lo != 0) begin nerr++; $display("FAIL load_stall got stall=%0d oe=%0d we=%0d exp %0d,%0d,0", stall, oe_lo, we_lo, e, e); end
    nvec++; if (rdat !== 32'hDEADBEEF) begin nerr++; $display("FAIL load_data got=%h exp=deadbeef", rdat); end
    nvec++; if (dq_bad != 0) begin nerr++; $display("FAIL load_bus got=%0d contended cycles exp=0", dq_bad); end
  endtask
  task automatic test_back_to_back();
    int e1, e2;
    int s1, ab1;
    e1 = model(1'b1, 1'b0, 32'd1028, 32'h12345678);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678);
    s1 = stall; ab1 = addr_bad;
    e2 = model(1'b0, 1'b1, 32'd1028, 32'h0);
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    nvec++; if (s1 != e1 || stall != e2) begin nerr++; $display("FAIL b2b_stall got=%0d,%0d exp=%0d,%0d", s1, stall, e1, e2); end
    nvec++; if (ab1 != 0 || addr_bad != 0) begin nerr++; $display("FAIL b2b_addr got=%0d,%0d bad exp=0,0", ab1, addr_bad); end
    nvec++; if (rdat !== 32'h12345678) begin nerr++; $display("FAIL b2b_data got=%h exp=12345678", rdat); end
    drop();
    repeat (2) @(negedge clk);
    #1;
    nvec++; if (read_data !== 32'h12345678) begin nerr++; $display("FAIL rdata_hold got=%h exp=12345678", read_data); end
  endtask
  task automatic test_priority();
    int e = model(1'b1, 1'b1, 32'd2000, 32'hA5A55A5A);
    access(1'b1, 1'b1, 32'd2000, 32'hA5A55A5A);
    nvec++; if (we_lo != e || oe_lo != 0) begin nerr++; $display("FAIL prio_strobe got we=%0d oe=%0d exp we=%0d oe=0", we_lo, oe_lo, e); end
    e = model(1'b0, 1'b1, 32'd2000, 32'h0);
    access(1'b0, 1'b1, 32'd2000, 32'h0);
    nvec++; if (rdat !== 32'hA5A55A5A || stall != e) begin nerr++; $display("FAIL prio_data got=%h/%0d exp=a5a55a5a/%0d", rdat, stall, e); end
  endtask
  task automatic test_reset_mid();
    int e;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028;
    repeat (2) @(negedge clk);
    #1;
    nvec++; if (SRAM_ADDR !== AW'(3) || SRAM_OE_N !== 1'b0) begin nerr++; $display("FAIL mid_hi got addr=%h oe=%b exp addr=3 oe=0", SRAM_ADDR, SRAM_OE_N); end
    rst = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    #1;
    bp_v = 1'b0;
    nvec++; if ({ready, SRAM_WE_N, SRAM_OE_N} !== 3'b111 || SRAM_ADDR !== AW'(0)) begin nerr++; $display("FAIL mid_rst_ctl got rdy=%b we=%b oe=%b addr=%h exp 1,1,1,0", ready, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR); end
    nvec++; if (read_data !== 32'h0) begin nerr++; $display("FAIL mid_rst_data got=%h exp=00000000", read_data); end
    rst = 1'b0;
    e = model(1'b0, 1'b1, 32'd1028, 32'h0);
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    nvec++; if (rdat !== 32'h12345678 || stall != e) begin nerr++; $display("FAIL post_rst_load got=%h/%0d exp=12345678/%0d", rdat, stall, e); end
  endtask
  task automatic test_random();
    logic [31:0] pool [6];
    for (int i = 0; i < 4; i++) pool[i] = BASE + 4 * $urandom_range(0, (1 << (AW - 1)) - 1) + $urandom_range(0, 3);
    pool[4] = pool[0] + 32'h0008_0000;
    pool[5] = BASE - 32'd4;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d = $urandom;
      void'(model(1'b1, 1'b0, pool[i], d));
      access(1'b1, 1'b0, pool[i], d);
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a = pool[$urandom_range(0, 5)];
      logic [31:0] d = $urandom;
      bit w = $urandom_range(0, 1) == 1;
      bit r = w ? ($urandom_range(0, 1) == 1) : 1'b1;
      int e = model(w, r, a, d);
      if ($urandom_range(0, 3) == 0) drop();
      access(w, r, a, d);
      nvec++; if (stall != e) begin nerr++; $display("FAIL rnd_stall n=%0d addr=%h got=%0d exp=%0d", n, a, stall, e); end
      nvec++; if (we_lo != (w ? e : 0) || oe_lo != (w ? 0 : e) || act_bad) begin nerr++; $display("FAIL rnd_strobe n=%0d got we=%0d oe=%0d done_active=%b exp we=%0d oe=%0d", n, we_lo, oe_lo, act_bad, w ? e : 0, w ? 0 : e); end
      nvec++; if (addr_bad != 0 || dq_bad != 0) begin nerr++; $display("FAIL rnd_bus n=%0d got addr_bad=%0d dq_bad=%0d exp 0,0", n, addr_bad, dq_bad); end
      if (!w) begin
        nvec++; if (rdat !== ref_mem[word_of(a)]) begin nerr++; $display("FAIL rnd_data n=%0d addr=%h got=%h exp=%h", n, a, rdat, ref_mem[word_of(a)]); end
      end
    end
    drop();
  endtask
`ifdef SRAM_LAST_READ_BYPASS_EN
  task automatic test_bypass();
    void'(model(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF));
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    void'(model(1'b0, 1'b1, 32'd1024, 32'h0));
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    nvec++; if (stall != 2 * W) begin nerr++; $display("FAIL bp_miss got=%0d exp=%0d", stall, 2 * W); end
    void'(model(1'b0, 1'b1, 32'd1024, 32'h0));
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    nvec++; if (stall != 0 || rdat !== 32'hDEADBEEF || act_bad) begin nerr++; $display("FAIL bp_hit got=%0d/%h exp=0/deadbeef", stall, rdat); end
    void'(model(1'b1, 1'b0, 32'd1024, 32'h1));
    access(1'b1, 1'b0, 32'd1024, 32'h1);
    void'(model(1'b0, 1'b1, 32'd1024, 32'h0));
    access(1'b0, 1'b1, 32'd1024, 32'h0);
    nvec++; if (stall != 0 || rdat !== 32'h1) begin nerr++; $display("FAIL bp_wr_upd got=%0d/%h exp=0/00000001", stall, rdat); end
    drop();
  endtask
`endif
  initial begin
    test_reset();
    test_idle();
    test_store_load();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    test_random();
`ifdef SRAM_LAST_READ_BYPASS_EN
    test_bypass();
`endif
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage controller between the EXE stage register (address, store value, read/write enables) and the MEM stage register (read value); replaces the single-cycle data memory.
- Drives an external 16-bit asynchronous SRAM and performs each 32-bit word access as two half-word phases.
- Deasserts `ready` while an access is in progress. The pipeline freezes all stage registers and the PC while `ready`=0.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles per half-word phase (≥1).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- rd_en, in, 1: load request (MEM_R_EN from EXE stage register).
- wr_en, in, 1: store request (MEM_W_EN from EXE stage register).
- address, in, 32: byte address (ALU result).
- write_data, in, 32: store value.
- read_data, out, 32: loaded word to MEM stage register.
- ready, out, 1: 0 = freeze pipeline.
- SRAM_ADDR, out, SRAM_AW: half-word address.
- SRAM_DQ, inout, 16: data bus.
- SRAM_WE_N, out, 1: write strobe, active low.
- SRAM_OE_N, out, 1: output enable, active low.

Behaviour:
- Address mapping:
  - word = ((address - ADDR_BASE) mod 2^32) >> 2.
  - Low half-word address = {word, 0}; high half-word address = {word, 1}; both truncated to SRAM_AW bits.
  - Out-of-range addresses wrap silently.
  - Bits [15:0] go to the low address, bits [31:16] to the high address.
- States: IDLE, LO, HI, DONE. A counter `cnt` runs 0..WAIT_CYCLES-1 within LO and HI.
- IDLE:
  - If wr_en or rd_en → LO with cnt=0, latching op = write if wr_en else read. Write has priority if both are asserted.
  - Otherwise stay in IDLE.
- LO:
  - SRAM_ADDR = low address.
  - At cnt = WAIT_CYCLES-1 → HI with cnt=0. A read samples SRAM_DQ into lo_reg on that edge.
- HI:
  - SRAM_ADDR = high address.
  - At cnt = WAIT_CYCLES-1 → DONE. A read samples SRAM_DQ into hi_reg.
- DONE: one cycle, then → IDLE unconditionally.
- Request hold: address, write_data and the enables are held stable by the frozen pipeline from IDLE through DONE. They are sampled combinationally during LO/HI; only the op type is latched.
- Write strobing:
  - During write LO/HI: SRAM_WE_N=0 and SRAM_DQ driven with the corresponding half-word.
  - All other times: SRAM_WE_N=1 and SRAM_DQ high-Z.
- SRAM_OE_N = 0 during read LO/HI, 1 otherwise.
- read_data = {hi_reg, lo_reg}. It is registered, updated only by reads, and holds between accesses.
- ready = 1 when (IDLE and no request) or DONE; 0 otherwise. It is combinational from state and enables.
- Latency:
  - Access = 2·WAIT_CYCLES+1 cycles from the first request cycle.
  - ready is low for 2·WAIT_CYCLES cycles, then high for the DONE cycle.
  - read_data is valid in the DONE cycle.
- Back-to-back accesses: after DONE the next request starts in IDLE on the following cycle. No lost or duplicated accesses.
- Reset, including mid-access:
  - state=IDLE, cnt=0, lo_reg/hi_reg/read_data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0.
  - A write interrupted by reset may leave the SRAM partially updated. This is acceptable.
- Non-memory instructions (rd_en=wr_en=0): ready=1 and no SRAM activity.

Optional Feature:
- Macro: SRAM_LAST_READ_BYPASS_EN.
- When defined:
  - A 1-entry tag register {valid, word, data} is kept.
  - A read whose word matches a valid entry completes with zero stall: ready=1 in the request cycle and read_data=entry data combinationally, with no SRAM cycle.
  - A read miss fills the entry at DONE.
  - A write to the matching word updates the entry data with write_data at DONE; a write to another word leaves it unchanged.
  - Reset clears valid.
- When undefined: every read performs the full SRAM access. The entry logic is absent.

Test Plan:
- Single store (WAIT_CYCLES=2): wr_en=1, address=1024, write_data=0xDEADBEEF → ready low 4 cycles, SRAM half-word 0=0xBEEF, half-word 1=0xDEAD, SRAM_WE_N low 4 cycles, ready high in cycle 5.
- Load after store: rd_en=1, address=1024 → read_data=0xDEADBEEF in DONE cycle, SRAM_OE_N low 4 cycles, SRAM_DQ not driven by controller.
- Back-to-back: store 0x12345678 @1028 then load @1028 held continuously → two full accesses of 5 cycles each, read_data=0x12345678, SRAM_ADDR=2 then 3.
- Reset mid-read: assert rst during HI → next cycle state IDLE, ready=1 with no request, read_data=0, SRAM_WE_N=SRAM_OE_N=1.
- Idle/priority: rd_en=wr_en=0 → ready=1 and no SRAM activity; rd_en=wr_en=1 → write performed.
- Bypass (macro on): load @1024 twice → first takes 5 cycles, second ready=1 in same cycle with 0xDEADBEEF; store 0x1 @1024 then load → 0x00000001 with zero stall.
